// File: rtl/led_flash_driver_pkg.sv
// Shared types and helpers for the LED flash driver.
//   flash_state_t : per-channel flash FSM state
//   ms_to_cycles  : converts a duration in ms to clock cycles
package led_flash_driver_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } flash_state_t;

  // Whole-ms cycle count; the kHz rate is truncated first so it matches the board math.
  function automatic int unsigned ms_to_cycles(input int unsigned freq_hz,
                                               input int unsigned ms);
    return (freq_hz / 1000) * ms;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_flash_driver_flash_channel.sv
// One LED channel: flash FSM, shared on/gap down-counter and a depth-1 pending flag.
// Ports:
//   clock  - system clock (rising edge)
//   reset  - asynchronous active-high reset
//   trig_i - one-cycle event pulse
//   hold_i - level; forces the LED on while high
//   led_o  - registered LED drive
module flash_channel
  import led_flash_driver_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic trig_i,
  input  logic hold_i,
  output logic led_o
);

  localparam int unsigned CNT_W = $clog2(max_u(ON_CYCLES, GAP_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  flash_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             led_q, led_d;

  // State, counter, pending flag and LED register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
    end
  end

  // Next-state, counter and pending logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;

    unique case (state_q)
      IDLE: begin
        if (trig_i) begin
          state_d = ON;
          cnt_d   = ON_LOAD;
        end
      end
      ON: begin
        // A trig on the last on-cycle only queues the next flash.
        if (trig_i) pend_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          // Terminal gap cycle: a queued or same-cycle trig restarts with no extra gap.
          if (pend_q || trig_i) begin
            state_d = ON;
            cnt_d   = ON_LOAD;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (trig_i) pend_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase

    // hold only overrides the LED; the FSM keeps running underneath.
    led_d = (state_d == ON) | hold_i;
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_flash_driver.sv
// Turns per-channel event pulses and hold levels into visible LED flashes with a
// guaranteed minimum on-time and dark gap.
// Ports:
//   clock - system clock (rising edge)
//   reset - asynchronous active-high reset
//   trig  - one-cycle event pulses, one bit per channel
//   hold  - per-channel level forcing the LED on
//   led   - registered LED drive, one bit per channel
module led_flash_driver
  import led_flash_driver_pkg::*;
#(
  parameter int unsigned CHANNELS   = 8,
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned ON_MS      = 50,
  parameter int unsigned GAP_MS     = 20
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] trig,
  input  logic [CHANNELS-1:0] hold,
  output logic [CHANNELS-1:0] led
);

  localparam int unsigned ON_CYCLES  = ms_to_cycles(CLOCK_FREQ, ON_MS);
  localparam int unsigned GAP_CYCLES = ms_to_cycles(CLOCK_FREQ, GAP_MS);

  // Zero-length flashes or gaps would break the counter load values.
  if (ON_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_cfg
    $error("led_flash_driver: ON_CYCLES and GAP_CYCLES must both be >= 1");
  end

  // Fully independent channels.
  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    flash_channel #(
      .ON_CYCLES  (ON_CYCLES),
      .GAP_CYCLES (GAP_CYCLES)
    ) u_ch (
      .clock  (clock),
      .reset  (reset),
      .trig_i (trig[i]),
      .hold_i (hold[i]),
      .led_o  (led[i])
    );
  end

endmodule
